// File: rtl/clk_div_meter_if.sv
// Measurement bus for clk_div_meter: control in,
// high/low/period results and status flags out.
interface clk_div_meter_if #(
  parameter int CW = 16
);
  logic          en;
  logic          din;
  logic [CW-1:0] high_time;
  logic [CW-1:0] low_time;
  logic [CW:0]   period;
  logic          meas_valid;
  logic          balanced;
  logic          locked;
  logic          timeout;

  modport master (
    input  en,
    input  din,
    output high_time,
    output low_time,
    output period,
    output meas_valid,
    output balanced,
    output locked,
    output timeout
  );

  modport slave (
    output en,
    output din,
    input  high_time,
    input  low_time,
    input  period,
    input  meas_valid,
    input  balanced,
    input  locked,
    input  timeout
  );
endinterface

// File: rtl/clk_div_meter.sv
// Measures high/low/period of an async divided clock in clk cycles,
// with duty-balance, ratio-lock and counter-saturation flags.
module clk_div_meter #(
  parameter int CW         = 16,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  clk_div_meter_if.master  m
);
  localparam int MW = $clog2(STABLE_CNT + 1);
  localparam logic [MW-1:0] SC   = MW'(STABLE_CNT);
  localparam logic [MW-1:0] ONE  = MW'(1);
  localparam logic [CW-1:0] CMAX = '1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

  logic [1:0]    state;
  logic          s1, s2, d;
  logic [CW-1:0] hcnt, lcnt;
  logic [MW-1:0] mcnt, mnext;
  logic [CW:0]   pnew;
  logic [CW-1:0] diff;
  logic          rise, fall, sat, bal;

  assign rise = s2 & ~d;
  assign fall = ~s2 & d;
  assign pnew = {1'b0, hcnt} + {1'b0, lcnt};
  assign diff = (hcnt >= lcnt) ? hcnt - lcnt
                               : lcnt - hcnt;
  assign bal  = (diff <= CW'(1));
  assign sat  = (state == LOW) ? (lcnt == CMAX)
                               : (hcnt == CMAX);

  // previous period is the published one; mcnt==0 marks "none yet"
  always_comb begin
    mnext = ONE;
    if (mcnt != '0 && pnew == m.period)
      mnext = (mcnt == SC) ? SC : mcnt + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      d            <= 1'b0;
      state        <= IDLE;
      hcnt         <= '0;
      lcnt         <= '0;
      mcnt         <= '0;
      m.high_time  <= '0;
      m.low_time   <= '0;
      m.period     <= '0;
      m.meas_valid <= 1'b0;
      m.balanced   <= 1'b0;
      m.locked     <= 1'b0;
      m.timeout    <= 1'b0;
    end else begin
      s1           <= m.din;
      s2           <= s1;
      d            <= s2;
      m.meas_valid <= 1'b0;
      if (!m.en) begin
        state    <= IDLE;
        hcnt     <= '0;
        lcnt     <= '0;
        mcnt     <= '0;
        m.locked  <= 1'b0;
        m.timeout <= 1'b0;
      end else if (state != IDLE && sat) begin
        // saturation beats any coincident edge
        state     <= SYNC;
        hcnt      <= '0;
        mcnt      <= '0;
        m.locked  <= 1'b0;
        m.timeout <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            state <= SYNC;
            hcnt  <= '0;
          end
          SYNC: begin
            if (rise) begin
              hcnt  <= CW'(1);
              state <= HIGH;
            end else begin
              hcnt <= hcnt + CW'(1);
            end
          end
          HIGH: begin
            if (fall) begin
              lcnt  <= CW'(1);
              state <= LOW;
            end else if (s2) begin
              hcnt <= hcnt + CW'(1);
            end
          end
          LOW: begin
            if (rise) begin
              m.high_time  <= hcnt;
              m.low_time   <= lcnt;
              m.period     <= pnew;
              m.balanced   <= bal;
              m.meas_valid <= 1'b1;
              mcnt         <= mnext;
              m.locked     <= (mnext == SC);
              hcnt         <= CW'(1);
              state        <= HIGH;
            end else if (!s2) begin
              lcnt <= lcnt + CW'(1);
            end
          end
        endcase
      end
    end
  end
endmodule
